// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared types for the pipeline hazard / debug controller:
//   state_e   - debug FSM state encoding (2-bit: RUN, HALT, STEP, TRAPPED)
//   action_e  - the single per-cycle action chosen by the priority mux
//   ctrl_t    - bundle of pipeline control outputs, plus its idle value
//   REG_ZERO  - register $0, which never carries a real dependency
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALT    = 2'd1,
        ST_STEP    = 2'd2,
        ST_TRAPPED = 2'd3
    } state_e;

    // Only one action drives the pipeline controls in any cycle.
    // Priority: ACT_FREEZE > ACT_FLUSH > ACT_LU.
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_LU     = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

    // Pipeline control bundle. The clean_n bits are active-low: 1 keeps the
    // register contents, 0 clears that pipeline register to a NOP.
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_clean_n;
        logic idex_stall;
        logic idex_clean_n;
        logic freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_hold:      1'b0,
        ifid_hold:    1'b0,
        ifid_clean_n: 1'b1,
        idex_stall:   1'b0,
        idex_clean_n: 1'b1,
        freeze:       1'b0
    };

    localparam logic [4:0] REG_ZERO = 5'd0;

    // HALT and TRAPPED are the two states in which the core is stopped.
    function automatic logic is_stopped(input state_e s);
        return (s == ST_HALT) || (s == ST_TRAPPED);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage core datapath and the hazard / debug controller.
//   master : core side   - drives hazard, redirect, breakpoint and debug inputs
//   slave  : controller  - drives hold / clean / stall / freeze, status, counters
// Signals:
//   ifid_rs, ifid_rt, id_use_rt   ID-stage source operands
//   idex_memtoreg, idex_rt        load in EX and its destination register
//   ex_redirect, ex_trap          EX-stage control-flow events
//   if_pc, bp_en, bp_addr         fetch PC and hardware breakpoint
//   dbg_halt, dbg_step, dbg_run   debugger requests
//   pc_hold .. freeze             pipeline controls
//   halted, trapped               debug status
//   stall_cnt, flush_cnt          saturating performance counters
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             id_use_rt;
    logic             idex_memtoreg;
    logic [4:0]       idex_rt;
    logic             ex_redirect;
    logic             ex_trap;
    logic [31:0]      if_pc;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic             dbg_halt;
    logic             dbg_step;
    logic             dbg_run;

    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_clean_n;
    logic             idex_stall;
    logic             idex_clean_n;
    logic             freeze;
    logic             halted;
    logic             trapped;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_rs, ifid_rt, id_use_rt, idex_memtoreg, idex_rt,
               ex_redirect, ex_trap, if_pc, bp_en, bp_addr,
               dbg_halt, dbg_step, dbg_run,
        input  pc_hold, ifid_hold, ifid_clean_n, idex_stall, idex_clean_n,
               freeze, halted, trapped, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, id_use_rt, idex_memtoreg, idex_rt,
               ex_redirect, ex_trap, if_pc, bp_en, bp_addr,
               dbg_halt, dbg_step, dbg_run,
        output pc_hold, ifid_hold, ifid_clean_n, idex_stall, idex_clean_n,
               freeze, halted, trapped, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Combinational load-use hazard term. A load in EX whose destination is read
// by the instruction in ID cannot be forwarded in time, so ID must wait one
// cycle.
// Ports:
//   i_idex_memtoreg  EX instruction is a load
//   i_idex_rt        load destination register
//   i_ifid_rs        rs of the ID instruction (always read)
//   i_ifid_rt        rt of the ID instruction
//   i_id_use_rt      ID instruction actually reads rt
//   o_lu             load-use hazard present this cycle
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       i_idex_memtoreg,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    input  logic       i_id_use_rt,
    output logic       o_lu
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_idex_rt == i_ifid_rs);
    // rt is only a real source for R-type, store and branch instructions;
    // for I-type ALU ops and loads it is a destination and must not stall.
    assign w_rt_match = i_id_use_rt && (i_idex_rt == i_ifid_rt);

    // A load into $0 is architecturally discarded and creates no dependency.
    assign o_lu = i_idex_memtoreg && (i_idex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central pipeline controller for the 5-stage MIPS core. Inserts load-use
// bubbles, flushes wrong-path instructions on EX redirects and traps, and runs
// the debug FSM (breakpoint, halt, single-step, resume, trap halt).
// Parameters:
//   CNT_W         width of the saturating stall / flush counters
//   START_HALTED  1: come out of reset in HALT instead of RUN
// Ports:
//   clk           core clock, all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   bus           pipe_hazard_ctrl_if.slave - datapath inputs, controls,
//                 status and counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter bit START_HALTED = 1'b0
)(
    input logic                clk,
    input logic                rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam state_e           RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_bp_skip;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_lu;
    logic             w_bp_hit;
    logic             w_freeze;
    logic             w_trap_go;
    action_e          w_action;
    ctrl_t            w_ctrl;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_idex_memtoreg (bus.idex_memtoreg),
        .i_idex_rt       (bus.idex_rt),
        .i_ifid_rs       (bus.ifid_rs),
        .i_ifid_rt       (bus.ifid_rt),
        .i_id_use_rt     (bus.id_use_rt),
        .o_lu            (w_lu)
    );

    // A redirect in the same cycle means the fetched PC is wrong-path, so it
    // must not trigger the breakpoint. bp_skip masks the PC we just resumed at.
    assign w_bp_hit = (r_state == ST_RUN) && bus.bp_en && (bus.if_pc == bus.bp_addr)
                      && !r_bp_skip && !bus.ex_redirect;

    // -------------------------------------------------------------------------
    // Debug FSM: next state and freeze request.
    // A trap in an executing state beats halt requests and breakpoints: the
    // trap cycle flushes instead of freezing and the core parks in TRAPPED.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_freeze     = 1'b0;
        w_trap_go    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (bus.ex_trap) begin
                    w_trap_go    = 1'b1;
                    w_state_next = ST_TRAPPED;
                end else if (w_bp_hit || bus.dbg_halt) begin
                    // Freeze in the hit cycle itself so the PC stays on bp_addr.
                    w_freeze     = 1'b1;
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                w_freeze = 1'b1;
                if (bus.dbg_halt)
                    w_state_next = ST_HALT;
                else if (bus.dbg_run)
                    w_state_next = ST_RUN;
                else if (bus.dbg_step)
                    w_state_next = ST_STEP;
            end
            ST_STEP: begin
                // One unfrozen cycle; hazard and redirect rules apply normally.
                if (bus.ex_trap) begin
                    w_trap_go    = 1'b1;
                    w_state_next = ST_TRAPPED;
                end else begin
                    w_state_next = ST_HALT;
                end
            end
            ST_TRAPPED: begin
                w_freeze = 1'b1;
                if (bus.dbg_run)
                    w_state_next = ST_RUN;
            end
            default: w_state_next = RESET_STATE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Priority mux: freeze > flush (redirect or trap) > load-use bubble.
    // A trap together with a redirect still flushes both stages only once.
    // -------------------------------------------------------------------------
    always_comb begin
        w_ctrl   = CTRL_IDLE;
        w_action = ACT_NONE;
        if (w_freeze) begin
            w_action         = ACT_FREEZE;
            w_ctrl.pc_hold   = 1'b1;
            w_ctrl.ifid_hold = 1'b1;
            w_ctrl.freeze    = 1'b1;
        end else if (bus.ex_redirect || w_trap_go) begin
            w_action            = ACT_FLUSH;
            w_ctrl.ifid_clean_n = 1'b0;
            w_ctrl.idex_clean_n = 1'b0;
        end else if (w_lu) begin
            // Held for one cycle only: next cycle the load has moved to MEM
            // and its result can be forwarded.
            w_action          = ACT_LU;
            w_ctrl.pc_hold    = 1'b1;
            w_ctrl.ifid_hold  = 1'b1;
            w_ctrl.idex_stall = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State, breakpoint skip and saturating counters
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_bp_skip   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            // Leaving HALT/TRAPPED arms the skip; the first cycle that lets the
            // PC advance moves fetch past the breakpoint, so the skip drops.
            if (is_stopped(r_state) && (w_state_next != r_state))
                r_bp_skip <= 1'b1;
            else if (!w_ctrl.pc_hold)
                r_bp_skip <= 1'b0;

            if ((w_action == ACT_LU) && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;

            if ((w_action == ACT_FLUSH) && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.pc_hold      = w_ctrl.pc_hold;
    assign bus.ifid_hold    = w_ctrl.ifid_hold;
    assign bus.ifid_clean_n = w_ctrl.ifid_clean_n;
    assign bus.idex_stall   = w_ctrl.idex_stall;
    assign bus.idex_clean_n = w_ctrl.idex_clean_n;
    assign bus.freeze       = w_ctrl.freeze;
    assign bus.halted       = is_stopped(r_state);
    assign bus.trapped      = (r_state == ST_TRAPPED);
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule
